// File: rtl/hit_detector_pkg.sv
// Shared constants, report FSM encoding and helpers
// for the duck-hunt collision detector.
package hit_detector_pkg;

  localparam int NUM_BULLETS = 8;
  localparam int H_VISIBLE_DEF = 640;
  localparam int V_VISIBLE_DEF = 480;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  function automatic logic [3:0] popcount(
    input logic [NUM_BULLETS-1:0] v
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_BULLETS; i++)
      c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/bcd_sat_adder.sv
// Two-digit BCD add of a small increment,
// clamped at a decimal ceiling.
module bcd_sat_adder #(
  parameter int SCORE_MAX = 99
) (
  input  logic [7:0] value,
  input  logic [3:0] inc,
  output logic [7:0] sum
);

  localparam logic [3:0] MAX_T = 4'(SCORE_MAX / 10);
  localparam logic [3:0] MAX_O = 4'(SCORE_MAX % 10);

  logic [4:0] ones_raw;
  logic [4:0] ones_adj;
  logic [4:0] tens_raw;
  logic       carry;
  logic       over;

  always_comb begin
    ones_raw = {1'b0, value[3:0]} + {1'b0, inc};
    carry    = ones_raw > 5'd9;
    ones_adj = carry ? ones_raw - 5'd10 : ones_raw;
    tens_raw = {1'b0, value[7:4]} + {4'b0000, carry};
    over     = (tens_raw > {1'b0, MAX_T}) ||
               ((tens_raw == {1'b0, MAX_T}) &&
                (ones_adj > {1'b0, MAX_O}));
    sum      = over ? {MAX_T, MAX_O}
                    : {tens_raw[3:0], ones_adj[3:0]};
  end

endmodule

// File: rtl/hit_detector.sv
// Per-frame bullet/duck overlap measurement with
// a valid/ack hit report and saturating BCD score.
module hit_detector
  import hit_detector_pkg::*;
#(
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int MIN_OVERLAP = 4,
  parameter int SCORE_MAX   = 99
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       duck_draw,
  input  logic [7:0] shot_draw,
  input  logic       hit_ack,
  output logic       hit_valid,
  output logic [7:0] hit_mask,
  output logic [7:0] score,
  output logic       overrun
);

  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [3:0] MIN_T = 4'(MIN_OVERLAP);

  logic                   active;
  logic                   frame_end;
  logic [NUM_BULLETS-1:0] frame_mask;
  logic [7:0]             score_next;
  state_t                 state;

  assign active    = (hcount < H_VIS) && (vcount < V_VIS);
  assign frame_end = (vcount == V_VIS) && (hcount == 10'd0);

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_ovl
    logic [3:0] cnt;
    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset)
        cnt <= '0;
      else if (frame_end)
        cnt <= '0;
      else if (active && duck_draw && shot_draw[i] && cnt != 4'hf)
        cnt <= cnt + 4'd1;
    end
    assign frame_mask[i] = cnt >= MIN_T;
  end

  bcd_sat_adder #(
    .SCORE_MAX(SCORE_MAX)
  ) u_add (
    .value(score),
    .inc  (popcount(frame_mask)),
    .sum  (score_next)
  );

  assign hit_valid = (state == PENDING);

  // Score advances on every frame end, independent of the handshake.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hit_mask <= '0;
      score    <= '0;
      overrun  <= 1'b0;
    end else begin
      if (frame_end)
        score <= score_next;
      unique case (state)
        IDLE: begin
          if (frame_end && |frame_mask) begin
            hit_mask <= frame_mask;
            state    <= PENDING;
          end
        end
        PENDING: begin
          if (frame_end && |frame_mask) begin
            if (hit_ack) begin
              hit_mask <= frame_mask;
            end else begin
              hit_mask <= hit_mask | frame_mask;
              overrun  <= 1'b1;
            end
          end else if (hit_ack) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// Directed-vector bench for hit_detector on a
// shrunken raster (16x4 visible, 20-pixel lines).
module tb_hit_detector;

  localparam int HV = 16;
  localparam int VV = 4;
  localparam int HT = 20;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hcount = 10'd1;
  logic [9:0] vcount = 10'(VV);
  logic       duck_draw = 1'b1;
  logic [7:0] shot_draw = 8'hff;
  logic       hit_ack = 1'b0;
  logic       hit_valid;
  logic [7:0] hit_mask;
  logic [7:0] score;
  logic       overrun;

  int n_checks = 0;
  int n_fail = 0;
  int lens [8];
  logic ack_hold = 1'b0;

  hit_detector #(
    .H_VISIBLE  (HV),
    .V_VISIBLE  (VV),
    .MIN_OVERLAP(4),
    .SCORE_MAX  (99)
  ) dut (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .hcount   (hcount),
    .vcount   (vcount),
    .duck_draw(duck_draw),
    .shot_draw(shot_draw),
    .hit_ack  (hit_ack),
    .hit_valid(hit_valid),
    .hit_mask (hit_mask),
    .score    (score),
    .overrun  (overrun)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic set_lens(input logic [7:0] m, input int n);
    for (int i = 0; i < 8; i++)
      lens[i] = m[i] ? n : 0;
  endtask

  // Inactive filler: duck and all shots high, must never count.
  task automatic idle_inputs();
    hcount    = 10'd1;
    vcount    = 10'(VV);
    duck_draw = 1'b1;
    shot_draw = 8'hff;
    hit_ack   = ack_hold;
  endtask

  task automatic run_lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) begin
      for (int h = 0; h < HT; h++) begin
        vcount  = 10'(v);
        hcount  = 10'(h);
        hit_ack = ack_hold;
        if (h < HV) begin
          duck_draw = (v == 1) && (h >= 2) && (h < 14);
          for (int i = 0; i < 8; i++)
            shot_draw[i] = (v == 1) && (h >= 2) &&
                           (h < 2 + lens[i]);
        end else begin
          duck_draw = 1'b1;
          shot_draw = 8'hff;
        end
        @(posedge vga_clk);
        #1;
      end
    end
  endtask

  task automatic end_frame(input logic ack_e);
    hcount    = 10'd0;
    vcount    = 10'(VV);
    duck_draw = 1'b0;
    shot_draw = 8'h00;
    hit_ack   = ack_e;
    @(posedge vga_clk);
    #1;
    idle_inputs();
  endtask

  task automatic frame(input logic [7:0] m, input int n,
                       input logic ack_e);
    set_lens(m, n);
    run_lines(0, VV - 1);
    end_frame(ack_e);
  endtask

  task automatic ack_pulse();
    hit_ack = 1'b1;
    @(posedge vga_clk);
    #1;
    hit_ack = ack_hold;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge vga_clk);
    #1;
    reset = 1'b0;
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    check("rst_valid", {7'b0, hit_valid}, 8'h00);
    check("rst_mask", hit_mask, 8'h00);
    check("rst_score", score, 8'h00);
    check("rst_ovr", {7'b0, overrun}, 8'h00);

    frame(8'h04, 6, 1'b0);
    check("b2_valid", {7'b0, hit_valid}, 8'h01);
    check("b2_mask", hit_mask, 8'h04);
    check("b2_score", score, 8'h01);
    ack_pulse();
    check("b2_ack", {7'b0, hit_valid}, 8'h00);

    frame(8'h20, 3, 1'b0);
    check("b5_3_valid", {7'b0, hit_valid}, 8'h00);
    check("b5_3_score", score, 8'h01);
    frame(8'h20, 4, 1'b0);
    check("b5_4_valid", {7'b0, hit_valid}, 8'h01);
    check("b5_4_mask", hit_mask, 8'h20);
    check("b5_4_score", score, 8'h02);
    ack_pulse();

    do_reset();
    frame(8'h81, 5, 1'b0);
    check("n_mask", hit_mask, 8'h81);
    check("n_ovr", {7'b0, overrun}, 8'h00);
    frame(8'h08, 4, 1'b0);
    check("n1_valid", {7'b0, hit_valid}, 8'h01);
    check("n1_mask", hit_mask, 8'h89);
    check("n1_ovr", {7'b0, overrun}, 8'h01);
    check("n1_score", score, 8'h03);

    do_reset();
    frame(8'h01, 4, 1'b0);
    check("pa_mask", hit_mask, 8'h01);
    frame(8'h02, 4, 1'b1);
    check("pa_valid", {7'b0, hit_valid}, 8'h01);
    check("pa_mask2", hit_mask, 8'h02);
    check("pa_ovr", {7'b0, overrun}, 8'h00);
    check("pa_score", score, 8'h02);
    ack_pulse();
    check("pa_ack", {7'b0, hit_valid}, 8'h00);

    ack_hold = 1'b1;
    idle_inputs();
    frame(8'h40, 4, 1'b1);
    check("hold_valid", {7'b0, hit_valid}, 8'h01);
    check("hold_mask", hit_mask, 8'h40);
    @(posedge vga_clk);
    #1;
    check("hold_drop", {7'b0, hit_valid}, 8'h00);
    check("hold_score", score, 8'h03);

    do_reset();
    frame(8'hff, 4, 1'b1);
    check("s_08", score, 8'h08);
    frame(8'h01, 4, 1'b1);
    check("s_09", score, 8'h09);
    frame(8'h01, 4, 1'b1);
    check("s_10", score, 8'h10);
    for (int k = 1; k <= 10; k++) begin
      frame(8'hff, 4, 1'b1);
      check("s_run", score, to_bcd(10 + 8 * k));
    end
    frame(8'h7f, 4, 1'b1);
    check("s_97", score, 8'h97);
    frame(8'h0f, 4, 1'b1);
    check("s_99", score, 8'h99);
    frame(8'h01, 4, 1'b1);
    check("s_99b", score, 8'h99);
    check("s_ovr", {7'b0, overrun}, 8'h00);

    ack_hold = 1'b0;
    idle_inputs();
    do_reset();
    frame(8'h04, 6, 1'b0);
    check("mr_pend", {7'b0, hit_valid}, 8'h01);
    set_lens(8'h04, 6);
    run_lines(0, 1);
    #2 reset = 1'b1;
    #1;
    check("mr_valid", {7'b0, hit_valid}, 8'h00);
    check("mr_mask", hit_mask, 8'h00);
    check("mr_score", score, 8'h00);
    @(posedge vga_clk);
    #1 reset = 1'b0;
    run_lines(2, VV - 1);
    end_frame(1'b0);
    check("mr_next", {7'b0, hit_valid}, 8'h00);
    check("mr_nscore", score, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_detector.md
# hit_detector

Raster-synchronous collision detector for the duck-hunt datapath. It watches the per-pixel duck and bullet draw flags during the visible scan, the same flags the pixel multiplexer consumes, and measures per-bullet overlap with the duck sprite each frame. At end of frame it reports which bullets hit through a valid/ack handshake to the shot/duck game logic, and keeps a saturating BCD score for the LEDs. It is the consumer end of the drawer outputs: drawers write pixels, this block reads them back as game events.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines per frame
- MIN_OVERLAP, 4, overlapping pixels per frame required for a bullet to count as a hit (1..15)
- SCORE_MAX, 99, BCD saturation value

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high
- hcount  in  10  current pixel column from VGA timing
- vcount  in  10  current line from VGA timing
- duck_draw  in  1  duck sprite covers the pixel at (hcount, vcount), same cycle
- shot_draw  in  8  bit i = bullet i covers the pixel at (hcount, vcount), same cycle
- hit_ack  in  1  consumer accepts the current report
- hit_valid  out  1  report pending
- hit_mask  out  8  bit i = bullet i hit; valid only while hit_valid
- score  out  8  two BCD digits {tens, ones}
- overrun  out  1  sticky: a report was merged into an unacknowledged one

## Operation
- Active pixel: hcount < H_VISIBLE and vcount < V_VISIBLE. Only active pixels are sampled.
- Per bullet i: 4-bit overlap counter ovl[i]. It increments on active cycles where duck_draw & shot_draw[i] and saturates at 15.
- frame_end strobe: the cycle where vcount == V_VISIBLE and hcount == 0. Exactly one per frame.
- On frame_end, frame_mask[i] = (ovl[i] >= MIN_OVERLAP). All ovl[] clear to 0 in the same cycle. A pixel sample in that cycle cannot occur because it is not active.
- The report FSM has two states, IDLE and PENDING.
  - IDLE, frame_end with frame_mask != 0: hit_mask <= frame_mask; go to PENDING.
  - IDLE, frame_end with frame_mask == 0: stay in IDLE.
  - PENDING, hit_ack without a nonzero frame_end: go to IDLE. hit_mask holds its value; it is don't-care once invalid.
  - PENDING, nonzero frame_end without hit_ack: hit_mask <= hit_mask | frame_mask; overrun <= 1; stay in PENDING.
  - PENDING, hit_ack and nonzero frame_end in the same cycle: hit_mask <= frame_mask; stay in PENDING; no overrun.
- hit_valid = (state == PENDING).
- hit_ack is ignored in IDLE.
- Score:
  - On every frame_end, score <= min(score + popcount(frame_mask), SCORE_MAX).
  - This happens regardless of handshake state.
  - BCD arithmetic: add to the ones digit with decimal carry into tens.
  - Once at 99, score stays at 99.
- Reset, asynchronous and taking effect mid-frame or mid-handshake:
  - state = IDLE, hit_valid = 0, hit_mask = 0
  - ovl[] = 0, score = 8'h00, overrun = 0
- After reset deassertion, the first report uses only pixels sampled after deassertion.

## Timing
- Overlap counters update on the rising edge after the sampled cycle.
- hit_valid, hit_mask, score and overrun all update on the rising edge ending the frame_end cycle, so latency is 1 cycle from frame_end.
- hit_ack is sampled on the rising edge. hit_valid falls on that same edge, so it is visible low in the next cycle.
- The consumer may hold hit_ack high continuously. Each report is then valid for exactly 1 cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - NUM_BULLETS = 8
  - H_VISIBLE / V_VISIBLE defaults
  - the FSM state encoding, IDLE = 0 and PENDING = 1
- Sub-module bcd_sat_adder, combinational:
  - inputs: 8-bit BCD value and 4-bit increment (0..8)
  - output: saturated BCD sum
  - reused by any future score display logic
- Overlap counters are a generated array inside hit_detector.

## Test plan
- Duck at fixed box, bullet 2 overlapping 6 pixels on one line, no other bullets -> 1 cycle after frame_end: hit_valid = 1, hit_mask = 8'h04, score = 8'h01.
- Bullet 5 overlapping exactly 3 pixels (MIN_OVERLAP = 4) -> no hit_valid, score unchanged; repeat with 4 pixels -> hit_mask = 8'h20.
- Bullets 0 and 7 hit in frame N, hit_ack held low; bullet 3 hits in frame N+1 -> hit_mask = 8'h89, overrun = 1, score = 8'h03.
- Pending report with hit_ack asserted on the frame_end cycle carrying bullet 1 -> hit_valid stays 1, hit_mask = 8'h02, overrun stays 0.
- Preload score to 8'h97 via hits, then 4 bullets hit in one frame -> score = 8'h99; another hit frame -> stays 8'h99; also check 8'h09 + 1 = 8'h10.
- Reset asserted mid-frame with nonzero overlap counters and PENDING -> all outputs 0 immediately; the next frame with no overlap produces no report.
